// File: rtl/csr_irq_ctrl_pkg.sv
// Shared CSR peripheral definitions: modify encodings, interrupt controller
// register offsets and the common write/set/clear helper.
package csr_irq_ctrl_pkg;

   typedef enum logic [2:0] {
      CSR_MOD_NONE  = 3'b000,
      CSR_MOD_WRITE = 3'b001,
      CSR_MOD_SET   = 3'b010,
      CSR_MOD_CLEAR = 3'b011
   } csr_mod_e;

   localparam logic [11:0] IRQ_OFS_PENDING = 12'd0;
   localparam logic [11:0] IRQ_OFS_ENABLE  = 12'd1;
   localparam logic [11:0] IRQ_OFS_CLAIM   = 12'd2;
   localparam logic [11:0] IRQ_OFS_MODE    = 12'd3;

   function automatic logic [31:0] csr_apply(input logic [31:0] cur,
                                             input logic [31:0] wd,
                                             input logic [2:0]  op);
      logic [31:0] res;
      res = cur;
      case (op)
         CSR_MOD_WRITE: res = wd;
         CSR_MOD_SET:   res = cur | wd;
         CSR_MOD_CLEAR: res = cur & ~wd;
         default:       res = cur;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/csr_irq_prio.sv
// Lowest-set-bit encoder used to pick the claimed interrupt source.
module csr_irq_prio
   import csr_irq_ctrl_pkg::*;
#(
   parameter int COUNT = 8
) (
   input  logic [COUNT-1:0] vec,
   output logic             any,
   output logic [4:0]       index
);

   always_comb begin
      any   = |vec;
      index = 5'd0;
      // Scan downward so the lowest set bit is the last one assigned.
      for (int i = COUNT - 1; i >= 0; i--) begin
         if (vec[i]) index = 5'(i);
      end
   end

endmodule

// File: rtl/csr_irq_ctrl.sv
// CSR-mapped interrupt controller: edge-latched pending, enable mask, claim.
// Optional macro CSR_IRQ_LEVEL_EN adds a MODE register for level-sensitive sources.
module csr_irq_ctrl
   import csr_irq_ctrl_pkg::*;
#(
   parameter logic [11:0] BASE_ADDR = 12'hbc4,
   parameter int          COUNT     = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             read,
   input  logic [2:0]       modify,
   input  logic [31:0]      wdata,
   input  logic [11:0]      addr,
   output logic [31:0]      rdata,
   output logic             valid,
   input  logic [COUNT-1:0] src,
   output logic             irq,
   output logic             AVOID_WARNING
);

   logic [COUNT-1:0] prev_q, pending_q, pending_d, enable_q, enable_d;
   logic [COUNT-1:0] edge_c, active_c, claim_mask_c;
   logic [31:0]      rdata_q, rdata_d, tmp_pend_c, tmp_en_c;
   logic             valid_q, valid_d, irq_q, irq_d;
   logic             hit_pend, hit_en, hit_claim, hit_mode, claim_any;
   logic [4:0]       claim_idx;

   assign AVOID_WARNING = |wdata[31:COUNT];

   assign hit_pend  = (addr == BASE_ADDR + IRQ_OFS_PENDING);
   assign hit_en    = (addr == BASE_ADDR + IRQ_OFS_ENABLE);
   assign hit_claim = (addr == BASE_ADDR + IRQ_OFS_CLAIM);
`ifdef CSR_IRQ_LEVEL_EN
   logic [COUNT-1:0] mode_q, mode_d;
   logic [31:0]      tmp_mode_c;
   assign hit_mode  = (addr == BASE_ADDR + IRQ_OFS_MODE);
`else
   assign hit_mode  = 1'b0;
`endif

   assign edge_c   = src & ~prev_q;
   assign active_c = pending_q & enable_q;

   csr_irq_prio #(.COUNT(COUNT)) u_prio (
      .vec   (active_c),
      .any   (claim_any),
      .index (claim_idx)
   );

   always_comb begin
      pending_d    = pending_q;
      enable_d     = enable_q;
      claim_mask_c = COUNT'(1) << claim_idx;
      tmp_pend_c   = csr_apply(32'(pending_q), wdata, modify);
      tmp_en_c     = csr_apply(32'(enable_q), wdata, modify);
      if (hit_pend) pending_d = tmp_pend_c[COUNT-1:0];
      if (hit_en)   enable_d  = tmp_en_c[COUNT-1:0];
      if (hit_claim && read && claim_any) pending_d = pending_d & ~claim_mask_c;
      // New edges are merged last so they beat a same-cycle clear or claim.
      pending_d = pending_d | edge_c;
`ifdef CSR_IRQ_LEVEL_EN
      mode_d     = mode_q;
      tmp_mode_c = csr_apply(32'(mode_q), wdata, modify);
      if (hit_mode) mode_d = tmp_mode_c[COUNT-1:0];
      pending_d = (pending_d & ~mode_q) | (src & mode_q);
`endif
      irq_d   = |active_c;
      valid_d = hit_pend | hit_en | hit_claim | hit_mode;
      rdata_d = 32'd0;
      if (hit_pend)  rdata_d = 32'(pending_q);
      if (hit_en)    rdata_d = 32'(enable_q);
      if (hit_claim && claim_any) rdata_d = 32'(claim_idx) + 32'd1;
`ifdef CSR_IRQ_LEVEL_EN
      if (hit_mode)  rdata_d = 32'(mode_q);
`endif
   end

   // Edge history tracks src through reset so held sources stay quiet.
   always_ff @(posedge clk) begin
      prev_q  <= src;
      rdata_q <= rdata_d;
      valid_q <= valid_d;
      if (!rstn) begin
         pending_q <= '0;
         enable_q  <= '0;
         irq_q     <= 1'b0;
      end else begin
         pending_q <= pending_d;
         enable_q  <= enable_d;
         irq_q     <= irq_d;
      end
   end

`ifdef CSR_IRQ_LEVEL_EN
   always_ff @(posedge clk) begin
      if (!rstn) mode_q <= '0;
      else       mode_q <= mode_d;
   end
`endif

   assign rdata = rdata_q;
   assign valid = valid_q;
   assign irq   = irq_q;

endmodule
